// File: rtl/chiplib_riscv_plic_target.sv
// Per-hart PLIC target: priority arbitration, external interrupt line,
// claim handshake FSM and complete pulse generation toward the gateways.
module chiplib_riscv_plic_target #(
  parameter  int NumSrc    = 31,
  parameter  int PrioWidth = 3,
  localparam int IdW       = $clog2(NumSrc + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NumSrc-1:0]             src_pend,
  input  logic [NumSrc-1:0]             src_en,
  input  logic [NumSrc*PrioWidth-1:0]   src_prio,
  input  logic [PrioWidth-1:0]          threshold,
  output logic                          eip,
  input  logic                          claim_valid,
  output logic                          claim_ready,
  output logic                          resp_valid,
  output logic [IdW-1:0]                resp_id,
  input  logic                          complete_valid,
  input  logic [IdW-1:0]                complete_id,
  output logic [NumSrc-1:0]             src_claim,
  output logic [NumSrc-1:0]             src_complete
);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    SETTLE
  } state_e;

  state_e              state_q, state_d;
  logic [IdW-1:0]      best_id_q, best_id_d;
  logic                best_vld_q, best_vld_d;
  logic [IdW-1:0]      resp_id_q, resp_id_d;
  logic                resp_valid_q, resp_valid_d;
  logic [NumSrc-1:0]   src_claim_q, src_claim_d;
  logic [NumSrc-1:0]   src_complete_q, src_complete_d;

  logic [PrioWidth-1:0] cur_prio;
  logic [PrioWidth-1:0] win_prio;

  // Pick the highest-priority eligible source; strict compare keeps lowest ID on ties.
  always_comb begin
    best_id_d  = '0;
    best_vld_d = 1'b0;
    win_prio   = '0;
    cur_prio   = '0;
    for (int i = 0; i < NumSrc; i++) begin
      cur_prio = src_prio[i*PrioWidth +: PrioWidth];
      if (src_pend[i] && src_en[i] &&
          (cur_prio > threshold) && (cur_prio > win_prio)) begin
        win_prio   = cur_prio;
        best_id_d  = IdW'(i + 1);
        best_vld_d = 1'b1;
      end
    end
  end

  // Claim FSM: accept in Idle, strobe in Ack, let the pend drop settle.
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    src_claim_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (claim_valid) begin
          state_d      = ACK;
          resp_valid_d = 1'b1;
          resp_id_d    = best_id_q;
          for (int i = 0; i < NumSrc; i++) begin
            src_claim_d[i] = (best_id_q == IdW'(i + 1));
          end
        end
      end
      ACK:     state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Complete decode; IDs outside 1..NumSrc never match any bit.
  always_comb begin
    src_complete_d = '0;
    for (int i = 0; i < NumSrc; i++) begin
      src_complete_d[i] = complete_valid && src_en[i] &&
                          (complete_id == IdW'(i + 1));
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      best_id_q      <= '0;
      best_vld_q     <= 1'b0;
      resp_id_q      <= '0;
      resp_valid_q   <= 1'b0;
      src_claim_q    <= '0;
      src_complete_q <= '0;
    end else begin
      state_q        <= state_d;
      best_id_q      <= best_id_d;
      best_vld_q     <= best_vld_d;
      resp_id_q      <= resp_id_d;
      resp_valid_q   <= resp_valid_d;
      src_claim_q    <= src_claim_d;
      src_complete_q <= src_complete_d;
    end
  end

  assign claim_ready  = (state_q == IDLE);
  assign eip          = best_vld_q && claim_ready;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign src_claim    = src_claim_q;
  assign src_complete = src_complete_q;

endmodule

// File: tb/tb_chiplib_riscv_plic_target.sv
// Bench for chiplib_riscv_plic_target: directed scenarios plus random
// traffic, every cycle compared against a transaction-level model.
module tb_chiplib_riscv_plic_target;

  localparam int N  = 31;
  localparam int PW = 3;
  localparam int IW = $clog2(N + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    src_pend;
  logic [N-1:0]    src_en;
  logic [N*PW-1:0] src_prio;
  logic [PW-1:0]   threshold;
  logic            eip;
  logic            claim_valid;
  logic            claim_ready;
  logic            resp_valid;
  logic [IW-1:0]   resp_id;
  logic            complete_valid;
  logic [IW-1:0]   complete_id;
  logic [N-1:0]    src_claim;
  logic [N-1:0]    src_complete;

  chiplib_riscv_plic_target #(.NumSrc(N), .PrioWidth(PW)) dut (
    .clk            (clk),
    .rst            (rst),
    .src_pend       (src_pend),
    .src_en         (src_en),
    .src_prio       (src_prio),
    .threshold      (threshold),
    .eip            (eip),
    .claim_valid    (claim_valid),
    .claim_ready    (claim_ready),
    .resp_valid     (resp_valid),
    .resp_id        (resp_id),
    .complete_valid (complete_valid),
    .complete_id    (complete_id),
    .src_claim      (src_claim),
    .src_complete   (src_complete)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Model state: registered winner, cycles until the next claim may be
  // taken, and the expected registered outputs.
  int           m_best;
  int           m_busy;
  int           m_resp_id;
  bit           m_resp_v;
  logic [N-1:0] m_claim;
  logic [N-1:0] m_comp;

  // Scan priorities from the top down; the first eligible ID found wins.
  function automatic int ref_best();
    for (int p = (1 << PW) - 1; p > int'(threshold); p--)
      for (int id = 1; id <= N; id++)
        if (src_pend[id-1] && src_en[id-1] &&
            int'(src_prio[(id-1)*PW +: PW]) == p)
          return id;
    return 0;
  endfunction

  task automatic tick();
    int nb;
    int cid;
    @(posedge clk);
    if (rst) begin
      m_best = 0; m_busy = 0; m_resp_id = 0;
      m_resp_v = 0; m_claim = '0; m_comp = '0;
    end else begin
      nb  = ref_best();
      cid = int'(complete_id);
      m_comp = '0;
      if (complete_valid && cid >= 1 && cid <= N && src_en[cid-1])
        m_comp[cid-1] = 1'b1;
      m_claim = '0;
      if (m_busy == 0 && claim_valid) begin
        m_resp_id = m_best;
        m_resp_v  = 1;
        if (m_best != 0) m_claim[m_best-1] = 1'b1;
        m_busy = 2;
      end else begin
        m_resp_v = 0;
        if (m_busy > 0) m_busy--;
      end
      m_best = nb;
    end
    @(negedge clk);
    chk("eip", eip, (m_best != 0 && m_busy == 0));
    chk("claim_ready", claim_ready, (m_busy == 0));
    chk("resp_valid", resp_valid, m_resp_v);
    chk("resp_id", resp_id, m_resp_id);
    chk("src_claim", src_claim, m_claim);
    chk("src_complete", src_complete, m_comp);
    // Gateway behaviour: a claimed source drops its pend flag.
    src_pend = src_pend & ~m_claim;
  endtask

  task automatic set_prio(int id, int p);
    src_prio[(id-1)*PW +: PW] = PW'(p);
  endtask

  int ids[$];
  int accs[$];
  logic [N-1:0] onehot;

  initial begin
    rst = 1; src_pend = '0; src_en = '1; src_prio = '0; threshold = '0;
    claim_valid = 0; complete_valid = 0; complete_id = '0;
    tick(); tick();
    rst = 0;
    tick();
    chk("rst_eip", eip, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_ready", claim_ready, 1);

    // Claim with nothing pending returns ID 0.
    claim_valid = 1; tick(); claim_valid = 0;
    chk("empty_resp_v", resp_valid, 1);
    chk("empty_resp_id", resp_id, 0);
    chk("empty_claim", src_claim, 0);
    tick(); tick();

    // Priority and tie-break.
    set_prio(3, 4); set_prio(5, 4); set_prio(7, 2);
    threshold = 1;
    src_pend = N'((1 << 2) | (1 << 4) | (1 << 6));
    tick();
    chk("prio_eip", eip, 1);
    ids = '{3, 5, 7};
    foreach (ids[k]) begin
      claim_valid = 1; tick(); claim_valid = 0;
      chk("prio_id", resp_id, ids[k]);
      onehot = '0; onehot[ids[k]-1] = 1'b1;
      chk("prio_onehot", src_claim, onehot);
      tick(); tick();
    end
    chk("prio_drained", eip, 0);

    // Threshold masking.
    src_prio = '0; set_prio(2, 3);
    src_pend = N'(1 << 1);
    threshold = 3; tick();
    chk("thr_mask", eip, 0);
    threshold = 2; tick();
    chk("thr_pass", eip, 1);

    // Back-to-back claims with claim_valid held high.
    src_pend = '0; src_prio = '0; threshold = 0;
    for (int i = 1; i <= 4; i++) begin
      set_prio(i, 1 + (i % 3));
      src_pend[i-1] = 1'b1;
    end
    tick();
    ids.delete(); accs.delete();
    claim_valid = 1;
    for (int c = 0; c < 13; c++) begin
      tick();
      if (m_resp_v) begin
        accs.push_back(c);
        ids.push_back(int'(resp_id));
        if (resp_id != 0) chk("b2b_eip_ack", eip, 0);
      end
    end
    claim_valid = 0;
    chk("b2b_count", accs.size(), 5);
    for (int k = 1; k < accs.size(); k++)
      chk("b2b_spacing", accs[k] - accs[k-1], 3);
    for (int a = 0; a < ids.size(); a++)
      for (int b = a + 1; b < ids.size(); b++)
        if (ids[a] != 0) chk("b2b_dup", (ids[a] == ids[b]), 0);
    tick(); tick();

    // Complete filtering.
    src_pend = '0; src_en = '1;
    complete_valid = 1; complete_id = 4; tick();
    onehot = '0; onehot[3] = 1'b1;
    chk("cmp_4", src_complete, onehot);
    complete_id = 0; tick();
    chk("cmp_0", src_complete, 0);
    complete_id = IW'(N + 1); tick();
    chk("cmp_oor", src_complete, 0);
    src_en[9] = 1'b0; complete_id = 10; tick();
    chk("cmp_dis", src_complete, 0);
    complete_valid = 0; src_en = '1; tick();

    // Claim and complete of the same ID in one cycle.
    src_prio = '0; set_prio(5, 5); src_pend = N'(1 << 4);
    tick();
    claim_valid = 1; complete_valid = 1; complete_id = 5;
    tick();
    claim_valid = 0; complete_valid = 0;
    onehot = '0; onehot[4] = 1'b1;
    chk("same_claim", src_claim, onehot);
    chk("same_cmp", src_complete, onehot);
    tick(); tick();

    // Reset in the Ack cycle.
    src_pend = N'(1 << 4); tick();
    claim_valid = 1; tick(); claim_valid = 0;
    chk("rmid_ack", resp_valid, 1);
    rst = 1; tick();
    chk("rmid_claim", src_claim, 0);
    chk("rmid_resp", resp_valid, 0);
    chk("rmid_ready", claim_ready, 1);
    rst = 0; tick();
    chk("rmid_norep", resp_valid, 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) src_pend = N'($urandom);
      if ($urandom_range(0, 7) == 0) src_en = N'($urandom | $urandom);
      if ($urandom_range(0, 15) == 0)
        for (int i = 1; i <= N; i++) set_prio(i, $urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) threshold = PW'($urandom_range(0, 7));
      claim_valid    = ($urandom_range(0, 2) == 0);
      complete_valid = $urandom_range(0, 1);
      complete_id    = IW'($urandom_range(0, N));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
